// File: rtl/cv_pad_ctrl.sv
// ColecoVision controller-port front end: registered keypad/joystick mux per port
// plus a rate-limited quadrature spinner fed by signed delta strobes.

module cv_pad_port #(
    parameter int SPIN_W = 8,
    parameter int ACC_W  = SPIN_W + 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              tick_i,
    input  logic [19:0]       pad_i,
    input  logic [SPIN_W-1:0] spin_delta_i,
    input  logic              spin_stb_i,
    input  logic              p5_i,
    input  logic              p8_i,
    output logic              p1_o,
    output logic              p2_o,
    output logic              p3_o,
    output logic              p4_o,
    output logic              p6_o,
    output logic              p7_o,
    output logic              p9_o
);
    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'(2**(ACC_W-1) - 1);
    localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;
    localparam logic signed [ACC_W:0] ONE     = (ACC_W+1)'(1);

    logic [3:0]              nib_q, nib_d;
    logic                    p6_q, p6_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]              ph_q, ph_d;
    logic [3:0]              key;
    logic signed [ACC_W:0]   sum;
    logic                    acc_pos, acc_neg;

    function automatic logic [3:0] key_code(input logic [3:0] k);
        case (k)
            4'd0:    return 4'b0011;
            4'd1:    return 4'b1110;
            4'd2:    return 4'b1101;
            4'd3:    return 4'b0110;
            4'd4:    return 4'b0001;
            4'd5:    return 4'b1001;
            4'd6:    return 4'b0111;
            4'd7:    return 4'b1100;
            4'd8:    return 4'b1000;
            4'd9:    return 4'b1011;
            4'd10:   return 4'b1010;
            4'd11:   return 4'b0101;
            4'd12:   return 4'b0100;
            default: return 4'b0010;
        endcase
    endfunction

    // Gray walk on {p7,p9}: 11 -> 10 -> 00 -> 01 -> 11 going forward.
    function automatic logic [1:0] ph_fwd(input logic [1:0] p);
        case (p)
            2'b11:   return 2'b10;
            2'b10:   return 2'b00;
            2'b00:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] ph_bwd(input logic [1:0] p);
        case (p)
            2'b11:   return 2'b01;
            2'b01:   return 2'b00;
            2'b00:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    always_comb begin
        // Scan high to low so the lowest pressed key is the one that sticks.
        key = 4'b1111;
        for (int k = 13; k >= 0; k--)
            if (pad_i[k]) key = key_code(4'(k));

        nib_d = 4'b1111;
        p6_d  = 1'b1;
        if (!p5_i && p8_i) begin
            nib_d = key;
            p6_d  = ~pad_i[19];
        end else if (p5_i && !p8_i) begin
            nib_d = {~pad_i[14], ~pad_i[15], ~pad_i[16], ~pad_i[17]};
            p6_d  = ~pad_i[18];
        end
    end

    always_comb begin
        acc_pos = ~acc_q[ACC_W-1] & (|acc_q);
        acc_neg = acc_q[ACC_W-1];
        sum     = {acc_q[ACC_W-1], acc_q};
        ph_d    = ph_q;
        if (spin_stb_i)
            sum = sum + {{(ACC_W+1-SPIN_W){spin_delta_i[SPIN_W-1]}}, spin_delta_i};
        // Step direction comes from the stored acc, not the freshly summed one.
        if (tick_i && acc_pos) begin
            sum  = sum - ONE;
            ph_d = ph_fwd(ph_q);
        end else if (tick_i && acc_neg) begin
            sum  = sum + ONE;
            ph_d = ph_bwd(ph_q);
        end
        if (sum > SUM_MAX)      acc_d = SUM_MAX[ACC_W-1:0];
        else if (sum < SUM_MIN) acc_d = SUM_MIN[ACC_W-1:0];
        else                    acc_d = sum[ACC_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            nib_q <= 4'b1111;
            p6_q  <= 1'b1;
            acc_q <= '0;
            ph_q  <= 2'b11;
        end else begin
            nib_q <= nib_d;
            p6_q  <= p6_d;
            acc_q <= acc_d;
            ph_q  <= ph_d;
        end
    end

    assign {p1_o, p2_o, p3_o, p4_o} = nib_q;
    assign p6_o = p6_q;
    assign p7_o = ph_q[1];
    assign p9_o = ph_q[0];
endmodule

module cv_pad_ctrl #(
    parameter int PORTS    = 2,
    parameter int SPIN_W   = 8,
    parameter int SPIN_DIV = 2048
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    clk_en_i,
    input  logic [PORTS*20-1:0]     pad_i,
    input  logic [PORTS*SPIN_W-1:0] spin_delta_i,
    input  logic [PORTS-1:0]        spin_stb_i,
    input  logic [PORTS-1:0]        ctrl_p5_i,
    input  logic [PORTS-1:0]        ctrl_p8_i,
    output logic [PORTS-1:0]        ctrl_p1_o,
    output logic [PORTS-1:0]        ctrl_p2_o,
    output logic [PORTS-1:0]        ctrl_p3_o,
    output logic [PORTS-1:0]        ctrl_p4_o,
    output logic [PORTS-1:0]        ctrl_p6_o,
    output logic [PORTS-1:0]        ctrl_p7_o,
    output logic [PORTS-1:0]        ctrl_p9_o
);
    localparam logic [15:0] PRE_LAST = 16'(SPIN_DIV - 1);

    logic [15:0] pre_q, pre_d;
    logic        tick;

    always_comb begin
        tick  = clk_en_i && (pre_q == PRE_LAST);
        pre_d = pre_q;
        if (clk_en_i) pre_d = tick ? 16'd0 : pre_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) pre_q <= '0;
        else            pre_q <= pre_d;
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_port
        cv_pad_port #(.SPIN_W(SPIN_W), .ACC_W(SPIN_W + 4)) u_port (
            .clk_i        (clk_i),
            .reset_n_i    (reset_n_i),
            .tick_i       (tick),
            .pad_i        (pad_i[20*g +: 20]),
            .spin_delta_i (spin_delta_i[SPIN_W*g +: SPIN_W]),
            .spin_stb_i   (spin_stb_i[g]),
            .p5_i         (ctrl_p5_i[g]),
            .p8_i         (ctrl_p8_i[g]),
            .p1_o         (ctrl_p1_o[g]),
            .p2_o         (ctrl_p2_o[g]),
            .p3_o         (ctrl_p3_o[g]),
            .p4_o         (ctrl_p4_o[g]),
            .p6_o         (ctrl_p6_o[g]),
            .p7_o         (ctrl_p7_o[g]),
            .p9_o         (ctrl_p9_o[g])
        );
    end
endmodule
